// File: rtl/simd_lane_alu_pipe.sv
// Packed-integer SIMD ALU: 8/16/32/64-bit lanes, two-stage valid/ready pipeline, per-byte sat flags.
// Optional sticky saturation flags with clear input when SIMD_LANE_ALU_STICKY_EN is defined.
module simd_lane_alu_pipe #(
  parameter int DATA_W = 128,
  parameter int SATC_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [4:0]          op,
  input  logic [1:0]          esz,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [DATA_W-1:0]   res,
  output logic [DATA_W/8-1:0] res_sat,
  output logic [SATC_W-1:0]   sat_cnt
`ifdef SIMD_LANE_ALU_STICKY_EN
  ,
  input  logic                sat_clr,
  output logic [DATA_W/8-1:0] sat_sticky
`endif
);

  localparam int NCH = DATA_W / 64;

  // One lane, operands zero-extended to 64 bits; returns {sat, result masked to lane width}.
  function automatic logic [64:0] f_lane(input logic [4:0] f_op, input logic [1:0] f_esz,
                                         input logic [63:0] la, input logic [63:0] lb);
    logic [63:0] mask, smax, smin, ax, bx, r, amt;
    logic [64:0] sum, dif;
    logic        sa, sb, sr, sat, ult, slt;
    int          w;
    case (f_esz)
      2'd0:    w = 8;
      2'd2:    w = 16;
      2'd1:    w = 32;
      default: w = 64;
    endcase
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    smax = mask >> 1;
    smin = mask ^ smax;
    sa   = |(la & smin);
    sb   = |(lb & smin);
    ax   = la | (sa ? ~mask : 64'd0);
    bx   = lb | (sb ? ~mask : 64'd0);
    sum  = {1'b0, la} + {1'b0, lb};
    dif  = {1'b0, la} - {1'b0, lb};
    ult  = la < lb;
    slt  = $signed(ax) < $signed(bx);
    amt  = lb & 64'(w - 1);
    r    = 64'd0;
    sat  = 1'b0;
    sr   = 1'b0;
    case (f_op)
      5'd0:  r = sum[63:0];
      5'd1:  r = dif[63:0];
      5'd2:  begin sat = |(sum & ~{1'b0, mask}); r = sat ? mask : sum[63:0]; end
      5'd3:  begin
        sr  = |(sum[63:0] & smin);
        sat = (sa == sb) && (sr != sa);
        r   = sat ? (sa ? smin : smax) : sum[63:0];
      end
      5'd4:  begin sat = ult; r = ult ? 64'd0 : dif[63:0]; end
      5'd5:  begin
        sr  = |(dif[63:0] & smin);
        sat = (sa != sb) && (sr != sa);
        r   = sat ? (sa ? smin : smax) : dif[63:0];
      end
      5'd6:  r = ult ? la : lb;
      5'd7:  r = slt ? la : lb;
      5'd8:  r = ult ? lb : la;
      5'd9:  r = slt ? lb : la;
      5'd10: r = (la == lb) ? mask : 64'd0;
      5'd11: r = (lb < la) ? mask : 64'd0;
      5'd12: r = ($signed(bx) < $signed(ax)) ? mask : 64'd0;
      5'd13: r = la << amt;
      5'd14: r = la >> amt;
      5'd15: r = $signed(ax) >>> amt;
      5'd16: r = la & lb;
      5'd17: r = la | lb;
      5'd18: r = la ^ lb;
      5'd19: r = la & ~lb;
      5'd20: r = lb;
      default: r = 64'd0;
    endcase
    return {sat, r & mask};
  endfunction

  // One 64-bit chunk: walks the lanes of the selected size; returns {byte sat flags, result}.
  function automatic logic [71:0] f_chunk(input logic [4:0] f_op, input logic [1:0] f_esz,
                                          input logic [63:0] ca, input logic [63:0] cb);
    logic [63:0] r, mask, la, lb;
    logic [64:0] lo;
    logic [7:0]  sv;
    int          nb;
    case (f_esz)
      2'd0:    nb = 1;
      2'd2:    nb = 2;
      2'd1:    nb = 4;
      default: nb = 8;
    endcase
    mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    r    = 64'd0;
    sv   = 8'd0;
    for (int k = 0; k < 8; k++) begin
      if (k % nb == 0) begin
        la = (ca >> (8 * k)) & mask;
        lb = (cb >> (8 * k)) & mask;
        lo = f_lane(f_op, f_esz, la, lb);
        r  = r | (lo[63:0] << (8 * k));
        if (lo[64]) sv = sv | (((8'd1 << nb) - 8'd1) << k);
      end
    end
    return {sv, r};
  endfunction

  logic                r_s1_vld;
  logic [4:0]          r_s1_op;
  logic [1:0]          r_s1_esz;
  logic [DATA_W-1:0]   r_s1_a, r_s1_b;
  logic                r_out_vld;
  logic [DATA_W-1:0]   r_res;
  logic [DATA_W/8-1:0] r_res_sat;
  logic [SATC_W-1:0]   r_sat_cnt;
  logic [DATA_W-1:0]   w_res;
  logic [DATA_W/8-1:0] w_sat;
  logic                w_s1_adv, w_s2_ld;

  for (genvar c = 0; c < NCH; c++) begin : g_chunk
    assign {w_sat[c*8 +: 8], w_res[c*64 +: 64]} =
      f_chunk(r_s1_op, r_s1_esz, r_s1_a[c*64 +: 64], r_s1_b[c*64 +: 64]);
  end

  assign w_s1_adv = ~r_out_vld | out_rdy;
  assign w_s2_ld  = w_s1_adv & r_s1_vld;
  assign in_rdy   = ~r_s1_vld | w_s1_adv;
  assign out_vld  = r_out_vld;
  assign res      = r_res;
  assign res_sat  = r_res_sat;
  assign sat_cnt  = r_sat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_op   <= '0;
      r_s1_esz  <= '0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_out_vld <= 1'b0;
      r_res     <= '0;
      r_res_sat <= '0;
      r_sat_cnt <= '0;
    end else begin
      if (w_s1_adv) r_out_vld <= r_s1_vld;
      if (w_s2_ld) begin
        r_res     <= w_res;
        r_res_sat <= w_sat;
        if ((|w_sat) && !(&r_sat_cnt)) r_sat_cnt <= r_sat_cnt + 1'b1;
      end
      if (in_rdy) begin
        r_s1_vld <= in_vld;
        if (in_vld) begin
          r_s1_op  <= op;
          r_s1_esz <= esz;
          r_s1_a   <= a;
          r_s1_b   <= b;
        end
      end
    end
  end

`ifdef SIMD_LANE_ALU_STICKY_EN
  logic [DATA_W/8-1:0] r_sticky;

  // A new saturation in the same cycle as a clear survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sticky <= '0;
    else     r_sticky <= (sat_clr ? '0 : r_sticky) | (w_s2_ld ? w_sat : '0);
  end

  assign sat_sticky = r_sticky;
`endif

endmodule
